bypass_network: RTL

BYPASS_NETWORK -- requirements
Module: bypass_network

---
 rtl/bypass_network_pkg.sv | 12 +
 rtl/bypass_sel.sv | 32 +++
 rtl/bypass_network.sv | 51 +++++
 3 files changed

// File: rtl/bypass_network_pkg.sv
// bypass_network_pkg: shared defaults, select encoding and tag entry type
package bypass_network_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int STAGES_DEF     = 2;
    localparam int LATE_STAGE_DEF = 1;
    localparam logic [2:0] SEL_RF = 3'd0;
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       late;
    } tag_t;
endpackage

// File: rtl/bypass_sel.sv
// bypass_sel: youngest-wins forwarding match and operand mux for one source
module bypass_sel
    import bypass_network_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int STAGES     = STAGES_DEF,
    parameter int LATE_STAGE = LATE_STAGE_DEF
) (
    input  logic [STAGES-1:0][$bits(tag_t)-1:0] tags,
    input  logic [4:0]                          src,
    input  logic [STAGES*XLEN-1:0]              stg_data,
    input  logic [XLEN-1:0]                     rf_data,
    output logic [XLEN-1:0]                     op,
    output logic [2:0]                          sel,
    output logic                                hazard
);
    tag_t t;
    always_comb begin
        op     = rf_data;
        sel    = SEL_RF;
        hazard = 1'b0;
        t      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            t = tag_t'(tags[i]);
            if (t.valid && t.rd == src && src != 5'd0) begin
                op     = stg_data[i*XLEN +: XLEN];
                sel    = 3'(i + 1);
                hazard = t.late && (i < LATE_STAGE);
            end
        end
    end
endmodule

// File: rtl/bypass_network.sv
// bypass_network: destination tag pipeline, operand forwarding and load-use stall
module bypass_network
    import bypass_network_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int STAGES     = STAGES_DEF,
    parameter int LATE_STAGE = LATE_STAGE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     flush,
    input  logic [4:0]               ex_rd,
    input  logic                     ex_wen,
    input  logic                     ex_late,
    input  logic [STAGES*XLEN-1:0]   stg_data,
    input  logic [4:0]               id_rs1,
    input  logic [4:0]               id_rs2,
    input  logic [XLEN-1:0]          rf_rs1_data,
    input  logic [XLEN-1:0]          rf_rs2_data,
    output logic [XLEN-1:0]          op_a,
    output logic [XLEN-1:0]          op_b,
    output logic [2:0]               sel_a,
    output logic [2:0]               sel_b,
    output logic                     stall,
    output logic [15:0]              stall_cnt
);
    tag_t [STAGES-1:0] tags;
    logic haz_a, haz_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else if (adv) begin
            tags[0] <= '{valid: ex_wen & ~flush & (ex_rd != 5'd0), rd: ex_rd, late: ex_late};
            for (int i = 1; i < STAGES; i++) tags[i] <= tags[i-1];
        end
    end
    bypass_sel #(.XLEN(XLEN), .STAGES(STAGES), .LATE_STAGE(LATE_STAGE)) u_sel_a (
        .tags(tags), .src(id_rs1), .stg_data(stg_data), .rf_data(rf_rs1_data),
        .op(op_a), .sel(sel_a), .hazard(haz_a)
    );
    bypass_sel #(.XLEN(XLEN), .STAGES(STAGES), .LATE_STAGE(LATE_STAGE)) u_sel_b (
        .tags(tags), .src(id_rs2), .stg_data(stg_data), .rf_data(rf_rs2_data),
        .op(op_b), .sel(sel_b), .hazard(haz_b)
    );
    assign stall = haz_a | haz_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule
